fast_corner_packer: RTL and testbench
=====================================

Name: fast_corner_packer

Overview:
- Transmit-side counterpart to the FAST corner pipeline: takes per-pixel corner events (x, y, score) and packs them into 32-bit stream words for the ARM DMA write channel.
- Buffers corners in an internal FIFO so DMA back-pressure does not stall detection.
- Closes each frame with one trailer word carrying the frame's corner count, marked with m_tlast.

Parameters:
- COL_NUM, 640, pixels per row; X_W = $clog2(COL_NUM) = 10.
- ROW_NUM, 480, rows per frame; Y_W = $clog2(ROW_NUM) = 9.
- SCORE_WIDTH, 8, corner score width.
- FIFO_DEPTH, 64, corner FIFO entries; must be a power of two, at least 4.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset, asynchronous, active-low.
- ce  in  1  global enable; when 0, no push, no pop, no state change, and outputs hold.
- corner_valid  in  1  corner event this cycle.
- corner_x  in  X_W  column.
- corner_y  in  Y_W  row.
- corner_score  in  SCORE_WIDTH  score.
- frame_end  in  1  one-cycle pulse after the last pixel of a frame.
- m_tdata  out  32  stream word.
- m_tvalid  out  1  word valid.
- m_tready  in  1  DMA accept.
- m_tlast  out  1  trailer word flag.
- overflow  out  1  sticky: a corner was dropped because the FIFO was full.
- frame_err  out  1  sticky: frame_end arrived while the previous trailer was still pending.

Behaviour:
- Reset (rst=0, asynchronous):
  - m_tvalid, m_tlast, overflow, frame_err = 0; m_tdata = 0.
  - FIFO empty; frame counter = 0; FSM = STREAM.
  - Assertion mid-transfer discards everything, including a pending trailer.
- Data word: m_tdata = {score[7:0], zero-extended y[11:0], zero-extended x[11:0]}, with m_tlast=0.
- Push:
  - When ce & corner_valid and the FIFO is not full, push the word.
  - Frame counter (16-bit) increments and saturates at 16'hFFFF.
  - If the FIFO is full, drop the corner, set overflow, and do not count it.
  - A push and a pop in the same cycle are allowed when full: the pop frees the slot first.
- Latency: a corner accepted in cycle N is visible on m_tvalid/m_tdata in cycle N+1 at the earliest. The FIFO output is show-ahead and registered.
- Handshake:
  - A word transfers when m_tvalid & m_tready & ce.
  - m_tdata and m_tlast stay stable while m_tvalid & !m_tready.
  - m_tvalid never drops without a transfer, except on reset.
- FSM states: STREAM, DRAIN, TRAILER.
  - STREAM: pop FIFO words as available. On frame_end:
    - latch trail_cnt = frame counter, including any same-cycle accepted corner;
    - latch drain_cnt = FIFO occupancy after this cycle's push/pop;
    - clear the frame counter;
    - go to DRAIN, or directly to TRAILER if drain_cnt = 0.
  - DRAIN: pop only; decrement drain_cnt per transfer. After the transfer where drain_cnt hits 0, go to TRAILER. New corners keep pushing and are counted for the next frame.
  - TRAILER:
    - m_tvalid=1, m_tdata={8'hFF, 8'h00, trail_cnt}, m_tlast=1.
    - On transfer, return to STREAM.
    - The trailer is valid the cycle after entering TRAILER.
- frame_end in DRAIN or TRAILER: ignored, frame_err set, frame counter not cleared.
- Empty frame (frame_end with no corners): trailer only, count 0.

Optional Feature:
- Macro: FAST_PACK_DROPCNT_EN.
- Defined:
  - An 8-bit saturating per-frame drop counter is kept; it is cleared with the frame counter.
  - Its value at frame_end is latched into trailer bits [23:16].
  - Extra output port drop_cnt[7:0] shows the live count.
- Undefined: trailer bits [23:16] = 0, no drop_cnt port, and overflow is the only drop indication.

Decomposition:
- Package fast_pkg:
  - X_W / Y_W derivation functions;
  - field offsets X_LSB=0, Y_LSB=12, SCORE_LSB=24;
  - TRAILER_TAG=8'hFF;
  - FSM state encoding.
- One sub-module, fast_sync_fifo:
  - parameterised width/depth, show-ahead, with full, empty and count outputs;
  - reused elsewhere in the pipeline.
- Packing and FSM stay in the top module.

Test Plan:
- 3 corners (10,20,5), (639,479,255), (0,0,1), then frame_end, m_tready=1 -> words 0x05014 00A, 0xFF1DF27F, 0x01000000, then 0xFF000003 with m_tlast=1.
- frame_end with no corners -> single word 0xFF000000, m_tlast=1, one cycle after the pulse.
- m_tready=0, 70 corners, FIFO_DEPTH=64 -> 64 stored, overflow=1; after frame_end and ready, 64 words then trailer count 0x0040 (drop field 6 with FAST_PACK_DROPCNT_EN).
- corner_valid and frame_end in the same cycle, then 2 next-frame corners during DRAIN -> the same-cycle corner is counted in the old trailer; next-frame corners appear after that trailer; next trailer count 2.
- Second frame_end during DRAIN with m_tready held low -> frame_err=1, one trailer emitted.
- Random m_tready toggling -> m_tdata stable while stalled; rst asserted mid-DRAIN -> m_tvalid=0 asynchronously, FIFO empty, no trailer afterwards.

Source files
------------

// File: rtl/fast_pkg.sv
// Shared constants, word layout and FSM encoding for the FAST corner packer.
// Pure declarations: no logic, no latency.
// No flow control of its own.
`timescale 1ns/1ps
package fast_pkg;

    localparam int FIELD_W     = 12;
    localparam int X_LSB       = 0;
    localparam int Y_LSB       = 12;
    localparam int SCORE_LSB   = 24;
    localparam logic [7:0] TRAILER_TAG = 8'hFF;

    typedef enum logic [1:0] {
        ST_STREAM  = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_TRAILER = 2'd2
    } state_t;

    function automatic int calc_x_w(input int col_num);
        return $clog2(col_num);
    endfunction

    function automatic int calc_y_w(input int row_num);
        return $clog2(row_num);
    endfunction

    function automatic logic [31:0] pack_word(input logic [FIELD_W-1:0] x,
                                              input logic [FIELD_W-1:0] y,
                                              input logic [7:0]         score);
        logic [31:0] w;
        w = '0;
        w[X_LSB +: FIELD_W]  = x;
        w[Y_LSB +: FIELD_W]  = y;
        w[SCORE_LSB +: 8]    = score;
        return w;
    endfunction

endpackage

// File: rtl/fast_sync_fifo.sv
// Show-ahead synchronous FIFO with a registered head word (zero when empty).
// Latency: a write into an empty FIFO appears on rd_dat the next cycle.
// Caller must not write when full unless it reads in the same cycle.
`timescale 1ns/1ps
module fast_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_dat,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_nxt;
    logic [AW:0]      count_nxt;

    always_comb begin
        rd_ptr_nxt = rd_ptr + AW'(rd_en);
        count_nxt  = count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= wr_dat;
    end

    // The next head is forwarded from the write port when that slot is written this cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rd_dat <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr_en);
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            if (count_nxt == '0)
                rd_dat <= '0;
            else if (wr_en && (wr_ptr == rd_ptr_nxt))
                rd_dat <= wr_dat;
            else
                rd_dat <= mem[rd_ptr_nxt];
        end
    end

endmodule

// File: rtl/fast_corner_packer.sv
// Packs corner events into 32-bit stream words and closes each frame with a count trailer.
// Latency: corner accepted in cycle N is on m_tdata in N+1; trailer one cycle after entering TRAILER.
// Backpressure: FIFO absorbs m_tready stalls, drops (sticky overflow) when full. Option: FAST_PACK_DROPCNT_EN.
`timescale 1ns/1ps
module fast_corner_packer
    import fast_pkg::*;
#(
    parameter  int COL_NUM     = 640,
    parameter  int ROW_NUM     = 480,
    parameter  int SCORE_WIDTH = 8,
    parameter  int FIFO_DEPTH  = 64,
    localparam int X_W         = calc_x_w(COL_NUM),
    localparam int Y_W         = calc_y_w(ROW_NUM)
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    input  logic                   corner_valid,
    input  logic [X_W-1:0]         corner_x,
    input  logic [Y_W-1:0]         corner_y,
    input  logic [SCORE_WIDTH-1:0] corner_score,
    input  logic                   frame_end,
    output logic [31:0]            m_tdata,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic                   m_tlast,
    output logic                   overflow,
`ifdef FAST_PACK_DROPCNT_EN
    output logic                   frame_err,
    output logic [7:0]             drop_cnt
`else
    output logic                   frame_err
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t          state, state_nxt;
    logic [CW-1:0]   drain_cnt, drain_nxt;
    logic [CW-1:0]   fifo_count, occ_nxt;
    logic [15:0]     frame_cnt, frame_cnt_sat, trail_cnt;
    logic [7:0]      trail_drop;
    logic [31:0]     fifo_rd_dat, corner_word;
    logic            fifo_full, fifo_empty;
    logic            push_req, push, drop, xfer, fifo_pop, fe, fe_accept;

    assign corner_word = pack_word(FIELD_W'(corner_x), FIELD_W'(corner_y), 8'(corner_score));

    assign m_tvalid  = (state == ST_TRAILER) | ~fifo_empty;
    assign m_tlast   = (state == ST_TRAILER);
    assign m_tdata   = (state == ST_TRAILER) ? {TRAILER_TAG, trail_drop, trail_cnt} : fifo_rd_dat;

    assign xfer      = m_tvalid & m_tready & ce;
    assign fifo_pop  = xfer & (state != ST_TRAILER);
    assign push_req  = ce & corner_valid;
    // A same-cycle pop frees the slot, so a full FIFO can still accept.
    assign push      = push_req & (~fifo_full | fifo_pop);
    assign drop      = push_req & ~push;
    assign fe        = ce & frame_end;
    assign fe_accept = fe & (state == ST_STREAM);
    assign occ_nxt   = fifo_count + CW'(push) - CW'(fifo_pop);
    assign frame_cnt_sat = (push && frame_cnt != 16'hFFFF) ? frame_cnt + 16'd1 : frame_cnt;

    fast_sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (push),
        .wr_dat (corner_word),
        .rd_en  (fifo_pop),
        .rd_dat (fifo_rd_dat),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    always_comb begin
        state_nxt = state;
        drain_nxt = drain_cnt;
        case (state)
            ST_STREAM: begin
                if (fe) begin
                    drain_nxt = occ_nxt;
                    state_nxt = (occ_nxt == '0) ? ST_TRAILER : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_pop) begin
                    drain_nxt = drain_cnt - CW'(1);
                    if (drain_cnt == CW'(1))
                        state_nxt = ST_TRAILER;
                end
            end
            ST_TRAILER: begin
                if (xfer)
                    state_nxt = ST_STREAM;
            end
            default: state_nxt = ST_STREAM;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_STREAM;
            drain_cnt <= '0;
            frame_cnt <= '0;
            trail_cnt <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
            overflow  <= overflow | drop;
            frame_err <= frame_err | (fe & ~fe_accept);
            if (fe_accept) begin
                trail_cnt <= frame_cnt_sat;
                frame_cnt <= '0;
            end else begin
                frame_cnt <= frame_cnt_sat;
            end
        end
    end

`ifdef FAST_PACK_DROPCNT_EN
    logic [7:0] drop_q, drop_sat;

    assign drop_sat = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    assign drop_cnt = drop_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_q     <= '0;
            trail_drop <= '0;
        end else if (fe_accept) begin
            trail_drop <= drop_sat;
            drop_q     <= '0;
        end else begin
            drop_q     <= drop_sat;
        end
    end
`else
    assign trail_drop = 8'h00;
`endif

endmodule

// File: tb/tb_fast_corner_packer.sv
// Directed, table-driven bench for fast_corner_packer; words are collected at the falling edge.
`timescale 1ns/1ps
module tb_fast_corner_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce = 1'b1;
    logic        corner_valid = 1'b0;
    logic [9:0]  corner_x = '0;
    logic [8:0]  corner_y = '0;
    logic [7:0]  corner_score = '0;
    logic        frame_end = 1'b0;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic        m_tlast;
    logic        overflow;
    logic        frame_err;
`ifdef FAST_PACK_DROPCNT_EN
    logic [7:0]  drop_cnt;
    localparam logic [7:0] EXP_DROP6 = 8'd6;
`else
    localparam logic [7:0] EXP_DROP6 = 8'd0;
`endif

    int checks = 0;
    int failures = 0;

    logic [32:0] got_q[$];
    logic        prev_stall = 1'b0;
    logic [32:0] prev_word = '0;

    typedef struct {
        int          x;      // -1 marks a frame_end cycle
        int          y;
        int          s;
        logic [32:0] exp;    // {tlast, tdata}
    } vec_t;

    vec_t t1[4];

    fast_corner_packer dut (
        .clk          (clk),
        .rst          (rst),
        .ce           (ce),
        .corner_valid (corner_valid),
        .corner_x     (corner_x),
        .corner_y     (corner_y),
        .corner_score (corner_score),
        .frame_end    (frame_end),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tlast      (m_tlast),
        .overflow     (overflow),
`ifdef FAST_PACK_DROPCNT_EN
        .frame_err    (frame_err),
        .drop_cnt     (drop_cnt)
`else
        .frame_err    (frame_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [32:0] dword(input int x, input int y, input int s);
        logic [11:0] xx, yy;
        logic [7:0]  ss;
        xx = 12'(x);
        yy = 12'(y);
        ss = 8'(s);
        return {1'b0, ss, yy, xx};
    endfunction

    function automatic logic [32:0] tword(input int cnt, input logic [7:0] drp);
        logic [15:0] c;
        c = 16'(cnt);
        return {1'b1, 8'hFF, drp, c};
    endfunction

    // Transfer capture and stall-stability check, both on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", {63'd0, m_tvalid}, 64'd1);
                chk("stall_word", {31'd0, m_tlast, m_tdata}, {31'd0, prev_word});
            end
            if (ce && m_tvalid && m_tready)
                got_q.push_back({m_tlast, m_tdata});
            prev_stall = m_tvalid && !(m_tready && ce);
            prev_word  = {m_tlast, m_tdata};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        ce = 1'b1;
        corner_valid = 1'b0;
        frame_end = 1'b0;
        m_tready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        got_q.delete();
        rst = 1'b1;
    endtask

    task automatic drive(input logic cv, input int x, input int y, input int s, input logic fe);
        corner_valid = cv;
        corner_x = 10'(x);
        corner_y = 9'(y);
        corner_score = 8'(s);
        frame_end = fe;
        tick();
        corner_valid = 1'b0;
        frame_end = 1'b0;
    endtask

    task automatic wait_words(input int n, input int budget, input string name);
        for (int c = 0; c < budget && got_q.size() < n; c++)
            @(posedge clk);
        #1;
        chk({name, "_count"}, 64'(got_q.size()), 64'(n));
    endtask

    task automatic check_q(input int idx, input logic [32:0] exp, input string name);
        if (idx < got_q.size())
            chk(name, {31'd0, got_q[idx]}, {31'd0, exp});
        else
            chk({name, "_missing"}, 64'd0, 64'd1);
    endtask

    initial begin
        t1[0] = '{10,  20,  5,   33'h0_0501400A};
        t1[1] = '{639, 479, 255, 33'h0_FF1DF27F};
        t1[2] = '{0,   0,   1,   33'h0_01000000};
        t1[3] = '{-1,  0,   0,   33'h1_FF000003};

        // Reset values
        rst = 1'b0;
        #12;
        chk("rst_tvalid", {63'd0, m_tvalid}, 64'd0);
        chk("rst_tlast", {63'd0, m_tlast}, 64'd0);
        chk("rst_overflow", {63'd0, overflow}, 64'd0);
        chk("rst_frame_err", {63'd0, frame_err}, 64'd0);
        chk("rst_tdata", {32'd0, m_tdata}, 64'd0);

        // Three corners and a trailer
        do_reset();
        m_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (t1[i].x < 0)
                drive(1'b0, 0, 0, 0, 1'b1);
            else
                drive(1'b1, t1[i].x, t1[i].y, t1[i].s, 1'b0);
            if (i == 0) begin
                chk("lat_tvalid", {63'd0, m_tvalid}, 64'd1);
                chk("lat_tdata", {32'd0, m_tdata}, 64'h0501400A);
            end
        end
        wait_words(4, 20, "t1");
        for (int i = 0; i < 4; i++)
            check_q(i, t1[i].exp, "t1_word");
        repeat (5) tick();
        chk("t1_no_extra", 64'(got_q.size()), 64'd4);

        // Empty frame: trailer only, one cycle after the pulse
        do_reset();
        m_tready = 1'b1;
        drive(1'b0, 0, 0, 0, 1'b1);
        chk("empty_tvalid", {63'd0, m_tvalid}, 64'd1);
        chk("empty_word", {31'd0, m_tlast, m_tdata}, {31'd0, 33'h1_FF000000});
        repeat (5) tick();
        chk("empty_count", 64'(got_q.size()), 64'd1);

        // Overflow: 70 corners into 64 entries while stalled
        do_reset();
        for (int i = 0; i < 70; i++)
            drive(1'b1, i, 2 * i, i + 1, 1'b0);
        chk("ovf_flag", {63'd0, overflow}, 64'd1);
        drive(1'b0, 0, 0, 0, 1'b1);
        m_tready = 1'b1;
        wait_words(65, 200, "ovf");
        for (int i = 0; i < 64; i++)
            check_q(i, dword(i, 2 * i, i + 1), "ovf_word");
        check_q(64, tword(64, EXP_DROP6), "ovf_trailer");

        // Same-cycle corner + frame_end, then next-frame corners during DRAIN
        do_reset();
        drive(1'b1, 1, 1, 1, 1'b0);
        drive(1'b1, 2, 2, 2, 1'b1);
        drive(1'b1, 3, 3, 3, 1'b0);
        drive(1'b1, 4, 4, 4, 1'b0);
        m_tready = 1'b1;
        wait_words(5, 30, "sc");
        drive(1'b0, 0, 0, 0, 1'b1);
        wait_words(6, 20, "sc2");
        check_q(0, dword(1, 1, 1), "sc_w0");
        check_q(1, dword(2, 2, 2), "sc_w1");
        check_q(2, tword(2, 8'd0), "sc_trl0");
        check_q(3, dword(3, 3, 3), "sc_w3");
        check_q(4, dword(4, 4, 4), "sc_w4");
        check_q(5, tword(2, 8'd0), "sc_trl1");

        // ce low: no push, no pop, outputs hold
        do_reset();
        m_tready = 1'b1;
        ce = 1'b0;
        drive(1'b1, 7, 7, 7, 1'b0);
        chk("ce_nopush", {63'd0, m_tvalid}, 64'd0);
        ce = 1'b1;
        m_tready = 1'b0;
        drive(1'b1, 8, 8, 8, 1'b0);
        ce = 1'b0;
        m_tready = 1'b1;
        repeat (3) tick();
        chk("ce_nopop", 64'(got_q.size()), 64'd0);
        chk("ce_hold", {31'd0, m_tvalid, m_tdata}, {31'd0, 1'b1, 32'h08008008});
        ce = 1'b1;
        drive(1'b0, 0, 0, 0, 1'b1);
        wait_words(2, 20, "ce");
        check_q(0, dword(8, 8, 8), "ce_w0");
        check_q(1, tword(1, 8'd0), "ce_trl");

        // Second frame_end during DRAIN
        do_reset();
        drive(1'b1, 5, 6, 7, 1'b0);
        drive(1'b0, 0, 0, 0, 1'b1);
        drive(1'b0, 0, 0, 0, 1'b1);
        chk("ferr_flag", {63'd0, frame_err}, 64'd1);
        m_tready = 1'b1;
        repeat (10) tick();
        chk("ferr_count", 64'(got_q.size()), 64'd2);
        check_q(0, dword(5, 6, 7), "ferr_w0");
        check_q(1, tword(1, 8'd0), "ferr_trl");

        // Random ready toggling
        do_reset();
        for (int i = 0; i < 11; i++) begin
            m_tready = 1'($urandom_range(0, 1));
            if (i < 10)
                drive(1'b1, 100 + i, 50 + i, 8'hA0 + i, 1'b0);
            else
                drive(1'b0, 0, 0, 0, 1'b1);
        end
        for (int c = 0; c < 400 && got_q.size() < 11; c++) begin
            m_tready = 1'($urandom_range(0, 1));
            tick();
        end
        chk("rnd_count", 64'(got_q.size()), 64'd11);
        for (int i = 0; i < 10; i++)
            check_q(i, dword(100 + i, 50 + i, 8'hA0 + i), "rnd_word");
        check_q(10, tword(10, 8'd0), "rnd_trl");

        // Reset in the middle of DRAIN
        do_reset();
        for (int i = 0; i < 5; i++)
            drive(1'b1, i, i, i, 1'b0);
        drive(1'b0, 0, 0, 0, 1'b1);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_tvalid", {63'd0, m_tvalid}, 64'd0);
        chk("arst_tlast", {63'd0, m_tlast}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        got_q.delete();
        rst = 1'b1;
        m_tready = 1'b1;
        repeat (10) tick();
        chk("arst_nowords", 64'(got_q.size()), 64'd0);
        chk("arst_idle", {63'd0, m_tvalid}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
